// File: rtl/spi_shift_reg_if.sv
// spi_shift_reg_if: bus bundle for the spi_shift_reg data path.
// The master modport is the controlling side (SPI engine or testbench), and the
// slave modport is the shift register itself.
// When SPI_SHREG_PARITY_EN is defined, the bundle also carries rx_parity.
interface spi_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             shift_en;
  logic             clear;
  logic             serial_in;
  logic             serial_out;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic             done;
  logic [CW-1:0]    bit_cnt;
`ifdef SPI_SHREG_PARITY_EN
  logic             rx_parity;

  modport master (
    output load, load_data, shift_en, clear, serial_in,
    input  serial_out, rx_data, busy, done, bit_cnt, rx_parity
  );

  modport slave (
    input  load, load_data, shift_en, clear, serial_in,
    output serial_out, rx_data, busy, done, bit_cnt, rx_parity
  );
`else
  modport master (
    output load, load_data, shift_en, clear, serial_in,
    input  serial_out, rx_data, busy, done, bit_cnt
  );

  modport slave (
    input  load, load_data, shift_en, clear, serial_in,
    output serial_out, rx_data, busy, done, bit_cnt
  );
`endif
endinterface

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: serial/parallel shift register with bit counter and done pulse.
// This is the data path shared by the SPI master and slave.
// A word is loaded in parallel and shifted out one bit per enabled cycle while
// serial_in is captured. The received word is then presented with a one-cycle
// done pulse.
// Optional feature: define SPI_SHREG_PARITY_EN to add the rx_parity output,
// which is the even-parity bit of each completed word.
// The WIDTH of the connected interface must equal this module's WIDTH.
module spi_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           reset,   // asynchronous, active low
  spi_shift_reg_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] rx_data_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] shift_next;
  logic             last_bit;

  // The shift direction is fixed at elaboration time. serial_out taps the end
  // of the register that leaves first.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shift_next     = {bus.serial_in, shreg_reg[WIDTH-1:1]};
      assign bus.serial_out = shreg_reg[0];
    end else begin : g_msb_first
      assign shift_next     = {shreg_reg[WIDTH-2:0], bus.serial_in};
      assign bus.serial_out = shreg_reg[WIDTH-1];
    end
  endgenerate

  assign last_bit = (bit_cnt_reg == CW'(1));

  // Frame FSM. busy and done are carried as their own flops so that both
  // outputs come straight from registers and never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      rx_data_reg <= '0;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else if (bus.clear) begin
      // Abort. The last completed word in rx_data is kept.
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.load) begin
            shreg_reg   <= bus.load_data;
            bit_cnt_reg <= CW'(WIDTH);
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.shift_en) begin
            shreg_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_reg - CW'(1);
            if (last_bit) begin
              rx_data_reg <= shift_next;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              state_reg   <= DONE;
            end
          end
        end
        DONE: begin
          done_reg <= 1'b0;
          // A load here starts the next frame without an idle gap cycle.
          if (bus.load) begin
            shreg_reg   <= bus.load_data;
            bit_cnt_reg <= CW'(WIDTH);
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT;
          end else begin
            state_reg   <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_SHREG_PARITY_EN
  logic rx_parity_reg;

  // Even parity of each completed word. It is updated on the same edge as
  // rx_data and survives clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_parity_reg <= 1'b0;
    end else if (!bus.clear && state_reg == SHIFT && bus.shift_en && last_bit) begin
      rx_parity_reg <= ^shift_next;
    end
  end

  assign bus.rx_parity = rx_parity_reg;
`endif

  assign bus.rx_data = rx_data_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.bit_cnt = bit_cnt_reg;
endmodule

// File: tb/tb_spi_shift_reg.sv
// tb_spi_shift_reg: drives an MSB-first and an LSB-first spi_shift_reg
// (WIDTH=8) with the same stimulus and checks each against hand-computed values.
// Define SPI_SHREG_PARITY_EN to also check rx_parity.
module tb_spi_shift_reg;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       shift_en = 1'b0;
  logic       clear = 1'b0;
  logic       serial_in = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_shift_reg_if #(.WIDTH(8)) m_if ();
  spi_shift_reg_if #(.WIDTH(8)) l_if ();

  assign m_if.load      = load;
  assign m_if.load_data = load_data;
  assign m_if.shift_en  = shift_en;
  assign m_if.clear     = clear;
  assign m_if.serial_in = serial_in;
  assign l_if.load      = load;
  assign l_if.load_data = load_data;
  assign l_if.shift_en  = shift_en;
  assign l_if.clear     = clear;
  assign l_if.serial_in = serial_in;

  spi_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (m_if.slave)
  );

  spi_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (l_if.slave)
  );

  // ld: word loaded; sin: serial_in bits, sent sin[7] first.
  // m_out/l_out: expected serial_out sequence, first bit in [7].
  typedef struct {
    logic [7:0] ld;
    logic [7:0] sin;
    logic [7:0] m_out;
    logic [7:0] m_rx;
    logic [7:0] l_out;
    logic [7:0] l_rx;
    logic       m_par;
    logic       l_par;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_m_busy"}, m_if.busy, 0);
    chk({tag, "_m_done"}, m_if.done, 0);
    chk({tag, "_m_bit_cnt"}, m_if.bit_cnt, 0);
    chk({tag, "_m_serial_out"}, m_if.serial_out, 0);
    chk({tag, "_l_serial_out"}, l_if.serial_out, 0);
    chk({tag, "_l_busy"}, l_if.busy, 0);
  endtask

  task automatic run_frame(input vec_t v, input int gap);
    load = 1'b1;
    load_data = v.ld;
    shift_en = 1'b0;
    tick();
    load = (gap > 0);
    for (int k = 0; k < 8; k++) begin
      chk("m_busy", m_if.busy, 1);
      chk("l_busy", l_if.busy, 1);
      chk("m_bit_cnt", m_if.bit_cnt, 8 - k);
      chk("l_bit_cnt", l_if.bit_cnt, 8 - k);
      chk("m_serial_out", m_if.serial_out, v.m_out[7-k]);
      chk("l_serial_out", l_if.serial_out, v.l_out[7-k]);
      serial_in = v.sin[7-k];
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      if (k < 7) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("stall_m_bit_cnt", m_if.bit_cnt, 7 - k);
          chk("stall_m_serial_out", m_if.serial_out, v.m_out[6-k]);
          chk("stall_l_serial_out", l_if.serial_out, v.l_out[6-k]);
          chk("stall_m_done", m_if.done, 0);
        end
      end
    end
    load = 1'b0;
    chk("m_done", m_if.done, 1);
    chk("l_done", l_if.done, 1);
    chk("m_busy_end", m_if.busy, 0);
    chk("m_bit_cnt_end", m_if.bit_cnt, 0);
    chk("m_rx_data", m_if.rx_data, v.m_rx);
    chk("l_rx_data", l_if.rx_data, v.l_rx);
`ifdef SPI_SHREG_PARITY_EN
    chk("m_rx_parity", m_if.rx_parity, v.m_par);
    chk("l_rx_parity", l_if.rx_parity, v.l_par);
`endif
    $display("frame ld=%02h sin=%02h gap=%0d m_rx=%02h l_rx=%02h", v.ld, v.sin, gap,
             m_if.rx_data, l_if.rx_data);
    tick();
    chk("m_done_pulse", m_if.done, 0);
    chk("m_busy_after", m_if.busy, 0);
  endtask

  initial begin
    int done_cnt;
    int first_done;
    int second_done;

    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 8'hFF, 8'h01, 8'hFF, 8'h80, 8'hFF, 1'b0, 1'b0};
    vecs[2] = '{8'h12, 8'h07, 8'h12, 8'h07, 8'h48, 8'hE0, 1'b1, 1'b1};
    vecs[3] = '{8'hF0, 8'hC3, 8'hF0, 8'hC3, 8'h0F, 8'hC3, 1'b0, 1'b0};

    // Reset state.
    tick();
    tick();
    chk_idle_zero("reset");
    chk("reset_m_rx_data", m_if.rx_data, 0);
    reset = 1'b1;
    tick();

    // Shift enable is ignored while idle.
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
    chk("idle_shift_bit_cnt", m_if.bit_cnt, 0);
    chk("idle_shift_busy", m_if.busy, 0);

    // Table-driven frames without stalls.
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i], 0);
      tick();
    end

    // Stalls of 3 cycles with load held high during the frame.
    run_frame(vecs[0], 3);
    tick();

    // Clear after 4 bits. rx_data (0x3C) must be kept.
    load = 1'b1;
    load_data = 8'h55;
    tick();
    load = 1'b0;
    serial_in = 1'b1;
    shift_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    shift_en = 1'b0;
    chk("pre_clear_bit_cnt", m_if.bit_cnt, 4);
    clear = 1'b1;
    load = 1'b1;
    shift_en = 1'b1;
    tick();
    clear = 1'b0;
    load = 1'b0;
    chk_idle_zero("clear");
    chk("clear_m_rx_kept", m_if.rx_data, 8'h3C);
    chk("clear_l_rx_kept", l_if.rx_data, 8'h3C);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_if.done || l_if.done) done_cnt++;
    end
    shift_en = 1'b0;
    chk("clear_no_done", done_cnt, 0);
    chk("clear_idle_bit_cnt", m_if.bit_cnt, 0);
    $display("clear mid-frame m_rx=%02h busy=%0b", m_if.rx_data, m_if.busy);

    // Asynchronous reset mid-frame, asserted between clock edges.
    load = 1'b1;
    load_data = 8'hFF;
    tick();
    load = 1'b0;
    shift_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_idle_zero("async_reset");
    chk("async_reset_m_rx", m_if.rx_data, 0);
    chk("async_reset_l_rx", l_if.rx_data, 0);
`ifdef SPI_SHREG_PARITY_EN
    chk("async_reset_m_parity", m_if.rx_parity, 0);
`endif
    tick();
    reset = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m_if.done || l_if.done || m_if.busy) done_cnt++;
    end
    shift_en = 1'b0;
    chk("reset_no_done", done_cnt, 0);
    $display("async reset mid-frame busy=%0b done=%0b", m_if.busy, m_if.done);

    // Back-to-back frames with shift_en held high throughout.
    serial_in = 1'b1;
    shift_en = 1'b1;
    load = 1'b1;
    load_data = 8'hA5;
    done_cnt = 0;
    first_done = -1;
    second_done = -1;
    for (int t = 1; t <= 25; t++) begin
      tick();
      load = 1'b0;
      if (t == 1) chk("b2b_load_wins_bit_cnt", m_if.bit_cnt, 8);
      if (m_if.done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = t;
          load = 1'b1;
          load_data = 8'h3C;
        end else if (second_done < 0) begin
          second_done = t;
        end
      end
      if (first_done > 0 && t == first_done + 1) chk("b2b_restart_bit_cnt", m_if.bit_cnt, 8);
    end
    shift_en = 1'b0;
    chk("b2b_done_count", done_cnt, 2);
    chk("b2b_first_done", first_done, 9);
    chk("b2b_spacing", second_done - first_done, 9);
    chk("b2b_m_rx", m_if.rx_data, 8'hFF);
    chk("b2b_l_rx", l_if.rx_data, 8'hFF);
    $display("back-to-back done at %0d and %0d", first_done, second_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
